// File: rtl/register_file_sb.sv
// Multi-port register file with a pending-write scoreboard and a serial clear
// engine that zeroes one register per cycle.
module register_file_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] a_select,
    input  logic [ADDR_WIDTH-1:0] b_select,
    input  logic [ADDR_WIDTH-1:0] d_select,
    output logic [DATA_WIDTH-1:0] port_a,
    output logic [DATA_WIDTH-1:0] port_b,
    output logic [DATA_WIDTH-1:0] port_d,
    input  logic [DATA_WIDTH-1:0] port_c,
    input  logic [ADDR_WIDTH-1:0] decoder_control,
    input  logic                  load_enable,
    input  logic [DATA_WIDTH-1:0] port_e,
    input  logic [ADDR_WIDTH-1:0] e_select,
    input  logic                  e_enable,
    input  logic [ADDR_WIDTH-1:0] mark_select,
    input  logic                  mark_enable,
    output logic                  busy_a,
    output logic                  busy_b,
    output logic                  busy_d,
    input  logic                  clear_start,
    output logic                  clear_busy,
    output logic                  clear_done
);

    localparam int REG_COUNT = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = ADDR_WIDTH'(REG_COUNT - 1);
    localparam logic [DATA_WIDTH-1:0] ZERO_DATA  = {DATA_WIDTH{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    logic [DATA_WIDTH-1:0] regs_r [REG_COUNT];
    logic [REG_COUNT-1:0]  pending_r;
    state_t                state_r;
    state_t                state_next_s;
    logic [ADDR_WIDTH-1:0] index_r;
    logic [ADDR_WIDTH-1:0] index_next_s;
    logic                  clear_busy_r;
    logic                  clear_done_r;
    logic                  idle_s;
    logic                  clearing_s;
    logic                  wr_c_s;
    logic                  wr_e_s;
    logic                  mark_s;

    // Hit on an enabled write destination for a given read select.
    function automatic logic write_hit(
        input logic                  en,
        input logic [ADDR_WIDTH-1:0] dest,
        input logic [ADDR_WIDTH-1:0] sel
    );
        return en && (dest == sel);
    endfunction

    // Read value with same-cycle bypass; port C takes priority over port E.
    function automatic logic [DATA_WIDTH-1:0] read_mux(
        input logic [ADDR_WIDTH-1:0] sel,
        input logic [DATA_WIDTH-1:0] stored,
        input logic                  c_en,
        input logic [ADDR_WIDTH-1:0] c_dest,
        input logic [DATA_WIDTH-1:0] c_data,
        input logic                  e_en,
        input logic [ADDR_WIDTH-1:0] e_dest,
        input logic [DATA_WIDTH-1:0] e_data
    );
        logic [DATA_WIDTH-1:0] val;
        if (write_hit(c_en, c_dest, sel)) begin
            val = c_data;
        end else if (write_hit(e_en, e_dest, sel)) begin
            val = e_data;
        end else begin
            val = stored;
        end
        return val;
    endfunction

    // Writes and marks are only honoured in IDLE; reset_n gating keeps the
    // read ports at zero while reset is held.
    assign idle_s     = (state_r == ST_IDLE);
    assign clearing_s = (state_r == ST_CLEAR);
    assign wr_c_s     = idle_s && load_enable && reset_n;
    assign wr_e_s     = idle_s && e_enable && reset_n;
    assign mark_s     = idle_s && mark_enable;

    // Combinational read ports with bypass.
    always_comb begin
        port_a = read_mux(a_select, regs_r[a_select], wr_c_s, decoder_control, port_c,
                          wr_e_s, e_select, port_e);
        port_b = read_mux(b_select, regs_r[b_select], wr_c_s, decoder_control, port_c,
                          wr_e_s, e_select, port_e);
        port_d = read_mux(d_select, regs_r[d_select], wr_c_s, decoder_control, port_c,
                          wr_e_s, e_select, port_e);
    end

    // Busy flags: pending unless an enabled write to that register lands now.
    always_comb begin
        busy_a = pending_r[a_select] &&
                 !(write_hit(wr_c_s, decoder_control, a_select) ||
                   write_hit(wr_e_s, e_select, a_select));
        busy_b = pending_r[b_select] &&
                 !(write_hit(wr_c_s, decoder_control, b_select) ||
                   write_hit(wr_e_s, e_select, b_select));
        busy_d = pending_r[d_select] &&
                 !(write_hit(wr_c_s, decoder_control, d_select) ||
                   write_hit(wr_e_s, e_select, d_select));
    end

    // Register array: clear engine, then port C, then port E.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_r[i] <= ZERO_DATA;
            end
        end else begin
            for (int i = 0; i < REG_COUNT; i++) begin
                if (clearing_s && (index_r == ADDR_WIDTH'(i))) begin
                    regs_r[i] <= ZERO_DATA;
                end else if (wr_c_s && (decoder_control == ADDR_WIDTH'(i))) begin
                    regs_r[i] <= port_c;
                end else if (wr_e_s && (e_select == ADDR_WIDTH'(i))) begin
                    regs_r[i] <= port_e;
                end
            end
        end
    end

    // Scoreboard: a new mark outranks a write retiring the old producer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_r <= {REG_COUNT{1'b0}};
        end else begin
            for (int i = 0; i < REG_COUNT; i++) begin
                if (clearing_s && (index_r == ADDR_WIDTH'(i))) begin
                    pending_r[i] <= 1'b0;
                end else if (mark_s && (mark_select == ADDR_WIDTH'(i))) begin
                    pending_r[i] <= 1'b1;
                end else if ((wr_c_s && (decoder_control == ADDR_WIDTH'(i))) ||
                             (wr_e_s && (e_select == ADDR_WIDTH'(i)))) begin
                    pending_r[i] <= 1'b0;
                end
            end
        end
    end

    // Clear sequencer next-state and index logic; the index saturates.
    always_comb begin
        state_next_s = state_r;
        index_next_s = index_r;
        case (state_r)
            ST_IDLE: begin
                if (clear_start) begin
                    state_next_s = ST_CLEAR;
                    index_next_s = {ADDR_WIDTH{1'b0}};
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (index_r == LAST_INDEX) begin
                    state_next_s = ST_DONE;
                end else begin
                    index_next_s = index_r + ADDR_WIDTH'(1);
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
                index_next_s = {ADDR_WIDTH{1'b0}};
            end
        endcase
    end

    // Sequencer state, index and status flags, registered from next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            index_r      <= {ADDR_WIDTH{1'b0}};
            clear_busy_r <= 1'b0;
            clear_done_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            index_r      <= index_next_s;
            clear_busy_r <= (state_next_s == ST_CLEAR);
            clear_done_r <= (state_next_s == ST_DONE);
        end
    end

    assign clear_busy = clear_busy_r;
    assign clear_done = clear_done_r;

endmodule

// File: tb/tb_register_file_sb.sv
// Directed self-checking bench for register_file_sb (default 32x16 configuration).
module tb_register_file_sb;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  a_select, b_select, d_select;
    logic [31:0] port_a, port_b, port_d;
    logic [31:0] port_c;
    logic [3:0]  decoder_control;
    logic        load_enable;
    logic [31:0] port_e;
    logic [3:0]  e_select;
    logic        e_enable;
    logic [3:0]  mark_select;
    logic        mark_enable;
    logic        busy_a, busy_b, busy_d;
    logic        clear_start;
    logic        clear_busy, clear_done;

    int          total  = 0;
    int          passed = 0;
    logic [31:0] exp_regs [16];
    int          done_seen;

    always #5 clk = ~clk;

    register_file_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_select(a_select), .b_select(b_select), .d_select(d_select),
        .port_a(port_a), .port_b(port_b), .port_d(port_d),
        .port_c(port_c), .decoder_control(decoder_control), .load_enable(load_enable),
        .port_e(port_e), .e_select(e_select), .e_enable(e_enable),
        .mark_select(mark_select), .mark_enable(mark_enable),
        .busy_a(busy_a), .busy_b(busy_b), .busy_d(busy_d),
        .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        a_select = 4'd0; b_select = 4'd0; d_select = 4'd0;
        port_c = 32'd0; decoder_control = 4'd0; load_enable = 1'b0;
        port_e = 32'd0; e_select = 4'd0; e_enable = 1'b0;
        mark_select = 4'd0; mark_enable = 1'b0; clear_start = 1'b0;

        // Reset state
        #12;
        check("rst_port_a", port_a, 32'd0);
        check("rst_port_d", port_d, 32'd0);
        check("rst_busy_a", {31'd0, busy_a}, 32'd0);
        check("rst_clear_busy", {31'd0, clear_busy}, 32'd0);
        check("rst_clear_done", {31'd0, clear_done}, 32'd0);
        #1 reset_n = 1'b1;
        tick();

        // Fill R0..R15 with their index via port C
        for (int i = 0; i < 16; i++) begin
            load_enable = 1'b1; decoder_control = 4'(i); port_c = 32'(i);
            exp_regs[i] = 32'(i);
            tick();
        end
        load_enable = 1'b0;
        for (int i = 0; i < 8; i++) begin
            a_select = 4'(2 * i); b_select = 4'(2 * i + 1);
            #1;
            check("sweep_a_even", port_a, 32'(2 * i));
            check("sweep_b_odd", port_b, 32'(2 * i + 1));
        end

        // C and E collide on R10: C wins, also in the bypass
        load_enable = 1'b1; decoder_control = 4'd10; port_c = 32'd50;
        e_enable = 1'b1; e_select = 4'd10; port_e = 32'd99;
        a_select = 4'd10;
        #1 check("collide_bypass", port_a, 32'd50);
        tick();
        load_enable = 1'b0; e_enable = 1'b0;
        #1 check("collide_stored", port_a, 32'd50);
        exp_regs[10] = 32'd50;

        // Dual write to different registers in one cycle
        load_enable = 1'b1; decoder_control = 4'd1; port_c = 32'd77;
        e_enable = 1'b1; e_select = 4'd2; port_e = 32'd88;
        b_select = 4'd2;
        #1 check("e_bypass_b", port_b, 32'd88);
        tick();
        load_enable = 1'b0; e_enable = 1'b0;
        a_select = 4'd1; b_select = 4'd2;
        #1;
        check("dual_c_r1", port_a, 32'd77);
        check("dual_e_r2", port_b, 32'd88);
        exp_regs[1] = 32'd77; exp_regs[2] = 32'd88;

        // Mark R3, then retire it with a port E write
        mark_enable = 1'b1; mark_select = 4'd3;
        tick();
        mark_enable = 1'b0; a_select = 4'd3;
        #1 check("mark_busy", {31'd0, busy_a}, 32'd1);
        e_enable = 1'b1; e_select = 4'd3; port_e = 32'd7;
        #1;
        check("retire_busy_now", {31'd0, busy_a}, 32'd0);
        check("retire_bypass", port_a, 32'd7);
        tick();
        e_enable = 1'b0;
        #1;
        check("retire_busy_after", {31'd0, busy_a}, 32'd0);
        check("retire_stored", port_a, 32'd7);
        exp_regs[3] = 32'd7;

        // Mark and write R5 together: data commits, pending stays
        mark_enable = 1'b1; mark_select = 4'd5;
        load_enable = 1'b1; decoder_control = 4'd5; port_c = 32'd20;
        tick();
        mark_enable = 1'b0; load_enable = 1'b0;
        a_select = 4'd5; b_select = 4'd5;
        #1;
        check("markwr_data", port_a, 32'd20);
        check("markwr_busy", {31'd0, busy_b}, 32'd1);
        exp_regs[5] = 32'd20;

        // Serial clear with a blocked C write, stray start and stray mark
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        load_enable = 1'b1; decoder_control = 4'd15; port_c = 32'd123;
        d_select = 4'd15;
        for (int k = 0; k < 16; k++) begin
            clear_start = (k == 5);
            mark_enable = (k == 12); mark_select = 4'd9;
            a_select = 4'(k);
            b_select = 4'(k - 1);
            #1;
            check("clr_busy", {31'd0, clear_busy}, 32'd1);
            check("clr_not_yet", port_a, exp_regs[k]);
            if (k > 0) begin
                check("clr_prev_zero", port_b, 32'd0);
            end else begin
                check("clr_no_done", {31'd0, clear_done}, 32'd0);
            end
            check("clr_no_bypass", port_d, (k == 15) ? exp_regs[15] : 32'd15);
            tick();
        end
        clear_start = 1'b0; mark_enable = 1'b0;
        #1;
        check("done_pulse", {31'd0, clear_done}, 32'd1);
        check("done_busy_low", {31'd0, clear_busy}, 32'd0);
        check("done_no_bypass", port_d, 32'd0);
        load_enable = 1'b0;
        tick();
        d_select = 4'd9; b_select = 4'd5; a_select = 4'd3;
        #1;
        check("idle_done_low", {31'd0, clear_done}, 32'd0);
        check("idle_busy_low", {31'd0, clear_busy}, 32'd0);
        check("idle_r3_zero", port_a, 32'd0);
        check("idle_mark_ignored", {31'd0, busy_d}, 32'd0);
        check("idle_pend_cleared", {31'd0, busy_b}, 32'd0);
        d_select = 4'd15;
        #1 check("idle_r15_zero", port_d, 32'd0);

        // Reset in the middle of a clear, at index 6
        load_enable = 1'b1; decoder_control = 4'd7; port_c = 32'd77;
        mark_enable = 1'b1; mark_select = 4'd8;
        tick();
        load_enable = 1'b0; mark_enable = 1'b0;
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        repeat (6) tick();
        a_select = 4'd7; b_select = 4'd8;
        #1;
        check("abort_pre_data", port_a, 32'd77);
        check("abort_pre_busy", {31'd0, busy_b}, 32'd1);
        check("abort_pre_clr", {31'd0, clear_busy}, 32'd1);
        #1 reset_n = 1'b0;
        #1;
        check("abort_data", port_a, 32'd0);
        check("abort_busy", {31'd0, busy_b}, 32'd0);
        check("abort_clear_busy", {31'd0, clear_busy}, 32'd0);
        check("abort_clear_done", {31'd0, clear_done}, 32'd0);
        #3 reset_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (clear_done || clear_busy) done_seen++;
        end
        check("abort_no_done", 32'(done_seen), 32'd0);
        check("abort_r7_zero", port_a, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/register_file_sb.md
REGISTER_FILE_SB -- requirements
Module: register_file_sb

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of each register and data port.
REQ-002 Parameter ADDR_WIDTH, default 4, select width; REG_COUNT = 2**ADDR_WIDTH registers.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 a_select, b_select, d_select  input  ADDR_WIDTH  read-port register selects.
REQ-006 port_a, port_b, port_d  output  DATA_WIDTH  read data, combinational from selects.
REQ-007 port_c  input  DATA_WIDTH  write data, primary write port C.
REQ-008 decoder_control  input  ADDR_WIDTH  destination register for port C.
REQ-009 load_enable  input  1  port C write enable.
REQ-010 port_e  input  DATA_WIDTH  write data, secondary write port E.
REQ-011 e_select  input  ADDR_WIDTH  destination register for port E.
REQ-012 e_enable  input  1  port E write enable.
REQ-013 mark_select  input  ADDR_WIDTH  register to mark pending.
REQ-014 mark_enable  input  1  scoreboard set request.
REQ-015 busy_a, busy_b, busy_d  output  1  pending status of selected register.
REQ-016 clear_start  input  1  request serial clear of all registers.
REQ-017 clear_busy  output  1  high while clear sequence runs.
REQ-018 clear_done  output  1  one-cycle pulse on clear completion.

Function
REQ-019 Writes SHALL commit at rising clk edge when enable high; port C and port E SHALL write in the same cycle to different registers.
REQ-020 C and E targeting same register same cycle: port C data SHALL be stored; port E write dropped.
REQ-021 Read bypass: if a read select equals an enabled write destination this cycle, port SHALL output that write data (port C over port E); otherwise stored contents.
REQ-022 Scoreboard: one pending bit per register; mark_enable SHALL set pending[mark_select] at next edge.
REQ-023 Any enabled write (C or E) to register r SHALL clear pending[r] at next edge.
REQ-024 Mark and write to same register same cycle: pending SHALL end set (new producer wins); data write still commits.
REQ-025 busy_x SHALL equal pending[x_select] AND NOT (enabled C or E write to x_select this cycle), consistent with bypass.
REQ-026 FSM states IDLE, CLEAR, DONE; reset state IDLE.
REQ-027 IDLE -> CLEAR on clear_start=1 at edge; index counter loads 0.
REQ-028 CLEAR: each cycle SHALL write 0 to reg[index] and clear pending[index], then index+1; after index REG_COUNT-1 -> DONE; occupancy exactly REG_COUNT cycles.
REQ-029 DONE: clear_done=1 for exactly one cycle, then IDLE.
REQ-030 clear_busy=1 in CLEAR only; clear_start in CLEAR or DONE SHALL be ignored.
REQ-031 During CLEAR and DONE, C/E writes and marks SHALL be ignored; reads return stored contents with no bypass; busy_x reflects pending only.
REQ-032 Index counter SHALL be ADDR_WIDTH bits, no wrap beyond REG_COUNT-1.

Reset
REQ-033 reset_n low SHALL immediately, without clk, zero all registers, all pending bits, index counter; FSM to IDLE.
REQ-034 Reset outputs: port_a/b/d = 0, busy_a/b/d = 0, clear_busy = 0, clear_done = 0.
REQ-035 Reset asserted mid-CLEAR SHALL abort sequence; no clear_done pulse afterwards.

Verification
REQ-036 Write R0..R15 = 0..15 via port C one per cycle; sweep a_select even, b_select odd -> port_a/port_b equal register index.
REQ-037 Same cycle C: R10=50, E: R10=99, a_select=10 -> port_a=50 combinationally; after edge R10 reads 50.
REQ-038 Mark R3; next cycle busy_a=1 (a_select=3); E writes 7 to R3 -> busy_a=0 and port_a=7 same cycle; after edge pending cleared.
REQ-039 Mark R5 and C write R5=20 same cycle -> R5=20, busy remains 1 afterwards.
REQ-040 Registers loaded nonzero, clear_start pulse -> clear_busy high 16 cycles, registers zero in ascending order, C write during CLEAR ignored, clear_done pulse 1 cycle, then IDLE.
REQ-041 reset_n low at CLEAR index 6 between edges -> all outputs zero immediately, FSM IDLE, no clear_done.
